banco_registro_wr_ctrl: RTL

Write-port controller for the 8-entry, 4-bit register bank. It shares the single write port (RegWrite/addrW/datW) between two requesters using round-robin arbitration. It also runs a clear sequencer that walks every address and writes the default value. Read ports are not touched; they connect straight to the bank.

---
 rtl/banco_pkg.sv | 13 +
 rtl/banco_registro_wr_ctrl_rr_arb2.sv | 35 +++
 rtl/banco_registro_wr_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/banco_pkg.sv
// Shared defaults and state encoding for the register-bank write-port controller.
package banco_pkg;

    localparam int unsigned DEF_DATA_W  = 4;
    localparam int unsigned DEF_ADDR_W  = 3;
    localparam int unsigned DEF_CLR_VAL = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/banco_registro_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from req[1:0]; the pointer moves past
// the winner whenever the parent takes the grant (advance).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;    // 1'b0 favours requester 0 on contention

    // Grant selection: a lone request wins outright, contention goes to the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer register: after a taken grant, favour the requester that lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            r_ptr <= grant[0];
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/banco_registro_wr_ctrl.sv
// Write-port controller for the register bank: round-robin sharing of the write port
// between two requesters plus a clear sweep. Optional macro BANCO_CLR_ON_RST_EN sweeps after reset.
module banco_registro_wr_ctrl
    import banco_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned CLR_VAL = DEF_CLR_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] dat0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dat1,
    output logic              ack1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] datW
);

    localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLR_VAL);

`ifdef BANCO_CLR_ON_RST_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic                w_cnt_last;

    logic [1:0]          w_grant;
    logic                w_advance;

    logic                w_regwrite_nxt;
    logic [ADDR_W-1:0]   w_addrw_nxt;
    logic [DATA_W-1:0]   w_datw_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                r_regwrite;
    logic [ADDR_W-1:0]   r_addrw;
    logic [DATA_W-1:0]   r_datw;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;
    logic                r_done;

    assign w_cnt_last = (r_cnt == LAST_ADDR);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .req     ({req1, req0}),
        .advance (w_advance),
        .grant   (w_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: clr_req is only honoured from IDLE, so a sweep never restarts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sweep counter: one extra bit so the last-address compare cannot alias on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if ((r_state == ST_CLEAR) && !w_cnt_last) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= '0;
        end
    end

    // Output logic: next values for the registered write port, acks and sweep flags.
    always_comb begin
        w_regwrite_nxt = 1'b0;
        w_addrw_nxt    = r_addrw;
        w_datw_nxt     = r_datw;
        w_ack0_nxt     = 1'b0;
        w_ack1_nxt     = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_advance = 1'b0;
                end else if (w_grant[0]) begin
                    w_advance      = 1'b1;
                    w_regwrite_nxt = 1'b1;
                    w_addrw_nxt    = addr0;
                    w_datw_nxt     = dat0;
                    w_ack0_nxt     = 1'b1;
                end else if (w_grant[1]) begin
                    w_advance      = 1'b1;
                    w_regwrite_nxt = 1'b1;
                    w_addrw_nxt    = addr1;
                    w_datw_nxt     = dat1;
                    w_ack1_nxt     = 1'b1;
                end else begin
                    w_advance = 1'b0;
                end
            end
            ST_CLEAR: begin
                w_regwrite_nxt = 1'b1;
                w_addrw_nxt    = r_cnt[ADDR_W-1:0];
                w_datw_nxt     = CLR_DATA;
                w_busy_nxt     = 1'b1;
                w_done_nxt     = w_cnt_last;
            end
            default: begin
                w_regwrite_nxt = 1'b0;
            end
        endcase
    end

    // Output registers: reset drops every output at once, aborting any sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite <= 1'b0;
            r_addrw    <= '0;
            r_datw     <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_regwrite <= w_regwrite_nxt;
            r_addrw    <= w_addrw_nxt;
            r_datw     <= w_datw_nxt;
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign RegWrite = r_regwrite;
    assign addrW    = r_addrw;
    assign datW     = r_datw;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign clr_busy = r_busy;
    assign clr_done = r_done;

endmodule
